// File: rtl/svm_pkg.sv
// Shared definitions for the pixel frame buffer and the downstream SVM stage:
// default frame geometry and the writer FSM state encoding.
package svm_pkg;

    localparam int XLEN_PIXEL_DEF    = 8;
    localparam int NUM_OF_PIXELS_DEF = 900;
    localparam int ADDR_WIDTH_DEF    = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } wr_state_e;

endpackage

// File: rtl/pixel_bram_sdp.sv
// Simple dual-port RAM written to infer block RAM: one write port, one read port
// with a registered output that is forced to zero on reset or out-of-range reads.
module pixel_bram_sdp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 900
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Write port: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: synchronous clear maps onto the RAM output-register reset pin.
    always_ff @(posedge clk) begin
        if (rst || (raddr_i >= DEPTH_LIM)) begin
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_frame_writer.sv
// Write side of the pixel frame buffer: fills the RAM from a valid/ready stream,
// then holds the frame with frame_done_o high until the consumer releases it.
module pixel_frame_writer
    import svm_pkg::*;
#(
    parameter int XLEN_PIXEL    = XLEN_PIXEL_DEF,
    parameter int NUM_OF_PIXELS = NUM_OF_PIXELS_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  s_valid_i,
    input  logic [XLEN_PIXEL-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic                  frame_done_o,
    input  logic                  release_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [XLEN_PIXEL-1:0] rd_data_o,
    output logic [ADDR_WIDTH-1:0] wr_count_o,
    output logic                  drop_err_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_OF_PIXELS - 1);

    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_count_q, wr_count_d;
    logic                  drop_err_q, drop_err_d;
    logic                  we_s;
    logic                  beat_s;

    assign s_ready_o    = (state_q == ST_LOAD);
    assign frame_done_o = (state_q == ST_FULL);
    assign beat_s       = s_valid_i && s_ready_o;

    // State, write counter and sticky drop flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_count_q <= {ADDR_WIDTH{1'b0}};
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Next-state logic; an accepted start always clears the count and drop flag.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        drop_err_d = drop_err_q;
        we_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_LOAD;
                    wr_count_d = {ADDR_WIDTH{1'b0}};
                    drop_err_d = 1'b0;
                end else if (s_valid_i) begin
                    drop_err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Abort wins over a same-cycle beat, which is discarded.
                if (start_i) begin
                    wr_count_d = {ADDR_WIDTH{1'b0}};
                    drop_err_d = 1'b0;
                end else if (beat_s) begin
                    we_s       = 1'b1;
                    wr_count_d = wr_count_q + ADDR_WIDTH'(1);
                    if (wr_count_q == LAST_IDX) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FULL: begin
                if (release_i && start_i) begin
                    state_d    = ST_LOAD;
                    wr_count_d = {ADDR_WIDTH{1'b0}};
                    drop_err_d = 1'b0;
                end else begin
                    if (release_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FULL;
                    end
                    if (s_valid_i) begin
                        drop_err_d = 1'b1;
                    end else begin
                        drop_err_d = drop_err_q;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wr_count_d = {ADDR_WIDTH{1'b0}};
                drop_err_d = 1'b0;
            end
        endcase
    end

    pixel_bram_sdp #(
        .DATA_W (XLEN_PIXEL),
        .ADDR_W (ADDR_WIDTH),
        .DEPTH  (NUM_OF_PIXELS)
    ) u_bram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_s),
        .waddr_i (wr_count_q),
        .wdata_i (s_data_i),
        .raddr_i (rd_addr_i),
        .rdata_o (rd_data_o)
    );

    assign wr_count_o = wr_count_q;
    assign drop_err_o = drop_err_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed self-checking bench for pixel_frame_writer: full frames, throttled
// input, drops while full, abort, release+start and mid-frame reset.
module tb_pixel_frame_writer;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic       s_valid_i;
    logic [7:0] s_data_i;
    logic       s_ready_o;
    logic       frame_done_o;
    logic       release_i;
    logic [9:0] rd_addr_i;
    logic [7:0] rd_data_o;
    logic [9:0] wr_count_o;
    logic       drop_err_o;

    int err_cnt;
    int chk_cnt;
    int ready_cycles;
    int early_done;
    int track_bad;

    pixel_frame_writer dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .s_valid_i    (s_valid_i),
        .s_data_i     (s_data_i),
        .s_ready_o    (s_ready_o),
        .frame_done_o (frame_done_o),
        .release_i    (release_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .wr_count_o   (wr_count_o),
        .drop_err_o   (drop_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stream n beats; data is the beat index or 8'h55. Optionally throttle valid.
    task automatic load_pixels(input int n, input bit toggle, input bit const55);
        int beats;
        int cyc;
        beats        = 0;
        cyc          = 0;
        ready_cycles = 0;
        early_done   = 0;
        track_bad    = 0;
        while (beats < n && cyc < 3 * n + 20) begin
            if (int'(wr_count_o) != beats) track_bad++;
            if (frame_done_o) early_done++;
            s_valid_i = toggle ? ((cyc % 2) == 0) : 1'b1;
            s_data_i  = const55 ? 8'h55 : beats[7:0];
            if (s_ready_o) ready_cycles++;
            if (s_valid_i && s_ready_o) beats++;
            step();
            cyc++;
        end
        s_valid_i = 1'b0;
        s_data_i  = 8'h00;
        check_eq("beats_in_budget", beats, n);
    endtask

    task automatic read_chk(input string tag, input int addr, input int exp);
        rd_addr_i = addr[9:0];
        step();
        check_eq(tag, int'(rd_data_o), exp);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        err_cnt   = 0;
        chk_cnt   = 0;
        rst       = 1'b1;
        start_i   = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = 8'h00;
        release_i = 1'b0;
        rd_addr_i = 10'd0;
        step();
        step();
        check_eq("rst_s_ready", int'(s_ready_o), 0);
        check_eq("rst_frame_done", int'(frame_done_o), 0);
        check_eq("rst_wr_count", int'(wr_count_o), 0);
        check_eq("rst_drop_err", int'(drop_err_o), 0);
        check_eq("rst_rd_data", int'(rd_data_o), 0);
        rst = 1'b0;
        step();

        // 1: back-to-back full frame
        pulse_start();
        check_eq("t1_ready_after_start", int'(s_ready_o), 1);
        load_pixels(900, 1'b0, 1'b0);
        check_eq("t1_ready_cycles", ready_cycles, 900);
        check_eq("t1_early_done", early_done, 0);
        check_eq("t1_count_track", track_bad, 0);
        check_eq("t1_frame_done", int'(frame_done_o), 1);
        check_eq("t1_s_ready_low", int'(s_ready_o), 0);
        check_eq("t1_wr_count", int'(wr_count_o), 900);
        read_chk("t1_rd0", 0, 0);
        read_chk("t1_rd1", 1, 1);
        read_chk("t1_rd899", 899, 131);
        read_chk("t1_rd_oob", 1000, 0);
        check_eq("t1_drop_err", int'(drop_err_o), 0);

        // 2: throttled frame
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        check_eq("t2_idle_done", int'(frame_done_o), 0);
        pulse_start();
        load_pixels(900, 1'b1, 1'b0);
        check_eq("t2_early_done", early_done, 0);
        check_eq("t2_count_track", track_bad, 0);
        check_eq("t2_frame_done", int'(frame_done_o), 1);
        check_eq("t2_wr_count", int'(wr_count_o), 900);
        read_chk("t2_rd899", 899, 131);

        // 3: valid and start while FULL without release
        s_valid_i = 1'b1;
        s_data_i  = 8'hAA;
        start_i   = 1'b1;
        step();
        s_valid_i = 1'b0;
        start_i   = 1'b0;
        check_eq("t3_drop_err", int'(drop_err_o), 1);
        check_eq("t3_still_full", int'(frame_done_o), 1);
        check_eq("t3_s_ready", int'(s_ready_o), 0);
        check_eq("t3_wr_count", int'(wr_count_o), 900);
        read_chk("t3_rd5", 5, 5);

        // 4: abort after 300 beats, then a constant frame
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        check_eq("t4_drop_held_idle", int'(drop_err_o), 1);
        pulse_start();
        check_eq("t4_drop_cleared", int'(drop_err_o), 0);
        load_pixels(300, 1'b0, 1'b0);
        check_eq("t4_partial_count", int'(wr_count_o), 300);
        s_valid_i = 1'b1;
        s_data_i  = 8'hEE;
        pulse_start();
        s_valid_i = 1'b0;
        check_eq("t4_abort_count", int'(wr_count_o), 0);
        check_eq("t4_abort_ready", int'(s_ready_o), 1);
        load_pixels(900, 1'b0, 1'b1);
        check_eq("t4_early_done", early_done, 0);
        check_eq("t4_frame_done", int'(frame_done_o), 1);
        check_eq("t4_wr_count", int'(wr_count_o), 900);
        track_bad = 0;
        for (int a = 0; a < 900; a++) begin
            rd_addr_i = a[9:0];
            step();
            if (rd_data_o != 8'h55) track_bad++;
        end
        check_eq("t4_all_55", track_bad, 0);

        // 5: release together with start while FULL
        release_i = 1'b1;
        start_i   = 1'b1;
        step();
        release_i = 1'b0;
        start_i   = 1'b0;
        check_eq("t5_s_ready", int'(s_ready_o), 1);
        check_eq("t5_frame_done", int'(frame_done_o), 0);
        check_eq("t5_wr_count", int'(wr_count_o), 0);

        // 6: reset mid-LOAD
        load_pixels(450, 1'b0, 1'b0);
        check_eq("t6_count_450", int'(wr_count_o), 450);
        read_chk("t6_rd3", 3, 3);
        rst = 1'b1;
        step();
        check_eq("t6_s_ready", int'(s_ready_o), 0);
        check_eq("t6_frame_done", int'(frame_done_o), 0);
        check_eq("t6_wr_count", int'(wr_count_o), 0);
        check_eq("t6_drop_err", int'(drop_err_o), 0);
        check_eq("t6_rd_data", int'(rd_data_o), 0);
        rst = 1'b0;
        step();
        check_eq("t6_idle_after", int'(s_ready_o), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
